// File: rtl/exe_hazard_ctrl.sv
// Execute-stage hazard controller: forwarding selects, load-use hold, long-op busy
// sequencing and wrong-path flush after a taken branch/jump, with saturating event counters.
module exe_hazard_ctrl #(
  parameter int LONG_LAT  = 4,
  parameter int FLUSH_LEN = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [4:0]       dec_rs_i,
  input  logic [4:0]       dec_rt_i,
  input  logic             dec_use_rs_i,
  input  logic             dec_use_rt_i,
  input  logic [4:0]       idex_rs_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             idex_reg_write_i,
  input  logic             idex_mem_read_i,
  input  logic             idex_long_op_i,
  input  logic             idex_nop_i,
  input  logic [4:0]       exmem_rd_i,
  input  logic             exmem_reg_write_i,
  input  logic             exmem_mem_read_i,
  input  logic             exmem_is_jump_i,
  input  logic             exmem_br_eq_i,
  input  logic             exmem_br_inc_i,
  input  logic             exmem_zero_i,
  input  logic [4:0]       memwb_rd_i,
  input  logic             memwb_reg_write_i,
  output logic [1:0]       for_a_o,
  output logic [1:0]       for_b_o,
  output logic             hold_front_o,
  output logic             stall_o,
  output logic             isJumped_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {S_RUN, S_BUSY, S_FLUSH} state_e;

  localparam logic [3:0] BUSY_INIT  = 4'(LONG_LAT > 2 ? LONG_LAT - 3 : 0);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_LEN > 1 ? FLUSH_LEN - 2 : 0);
  localparam logic       LONG_EN    = (LONG_LAT > 1);
  localparam logic [CNT_W-1:0] ONE  = 1;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic redirect, long_start, load_use;
  logic hold, stl, bsy, jmp, accept;

  assign redirect = exmem_is_jump_i | (exmem_br_eq_i & exmem_zero_i)
                  | (exmem_br_inc_i & ~exmem_zero_i);
  // The held long op is still in ID/EX on its release cycle; done_q stops it re-arming.
  assign long_start = LONG_EN & idex_long_op_i & ~idex_nop_i & ~done_q;
  assign load_use = idex_mem_read_i & idex_reg_write_i & (idex_rd_i != 5'd0)
                  & ((dec_use_rs_i & (dec_rs_i == idex_rd_i))
                   | (dec_use_rt_i & (dec_rt_i == idex_rd_i)));

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (exmem_reg_write_i && !exmem_mem_read_i && exmem_rd_i != 5'd0 && exmem_rd_i == src)
      return 2'b01;
    else if (memwb_reg_write_i && memwb_rd_i != 5'd0 && memwb_rd_i == src)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hold    = 1'b0;
    stl     = 1'b0;
    bsy     = 1'b0;
    jmp     = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (redirect) begin
          jmp    = 1'b1;
          accept = 1'b1;
          if (FLUSH_LEN > 1) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end else if (long_start) begin
          hold = 1'b1;
          stl  = 1'b1;
          bsy  = 1'b1;
          if (LONG_LAT > 2) begin
            state_d = S_BUSY;
            cnt_d   = BUSY_INIT;
          end else begin
            done_d = 1'b1;
          end
        end else if (load_use) begin
          hold = 1'b1;
        end
      end
      S_BUSY: begin
        hold = 1'b1;
        stl  = 1'b1;
        bsy  = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_RUN;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_FLUSH: begin
        jmp = 1'b1;
        if (redirect) begin
          accept = 1'b1;
          cnt_d  = FLUSH_INIT;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_RUN;
      cnt_q       <= 4'd0;
      done_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (hold && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + ONE;
      if (accept && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + ONE;
    end
  end

  assign for_a_o      = reset_i ? 2'b00 : fwd_sel(idex_rs_i);
  assign for_b_o      = reset_i ? 2'b00 : fwd_sel(idex_rt_i);
  assign hold_front_o = hold & ~reset_i;
  assign stall_o      = stl & ~reset_i;
  assign isJumped_o   = jmp & ~reset_i;
  assign busy_o       = bsy & ~reset_i;
  assign stall_cnt_o  = reset_i ? '0 : stall_cnt_q;
  assign flush_cnt_o  = reset_i ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Bench for exe_hazard_ctrl: directed scenarios plus randomized traffic against a
// cycle-count reference model.
module tb_exe_hazard_ctrl;
  localparam int LL = 4, FL = 2, CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0, reset = 1'b1;
  logic [4:0] dec_rs, dec_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic dec_use_rs, dec_use_rt, idex_reg_write, idex_mem_read, idex_long_op, idex_nop;
  logic exmem_reg_write, exmem_mem_read, exmem_is_jump, exmem_br_eq, exmem_br_inc, exmem_zero;
  logic memwb_reg_write;
  logic [1:0] for_a, for_b;
  logic hold_front, stall, isJumped, busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_tests = 0, n_fail = 0;

  exe_hazard_ctrl #(.LONG_LAT(LL), .FLUSH_LEN(FL), .CNT_W(CW)) dut (
    .clock_i(clock), .reset_i(reset),
    .dec_rs_i(dec_rs), .dec_rt_i(dec_rt), .dec_use_rs_i(dec_use_rs), .dec_use_rt_i(dec_use_rt),
    .idex_rs_i(idex_rs), .idex_rt_i(idex_rt), .idex_rd_i(idex_rd),
    .idex_reg_write_i(idex_reg_write), .idex_mem_read_i(idex_mem_read),
    .idex_long_op_i(idex_long_op), .idex_nop_i(idex_nop),
    .exmem_rd_i(exmem_rd), .exmem_reg_write_i(exmem_reg_write), .exmem_mem_read_i(exmem_mem_read),
    .exmem_is_jump_i(exmem_is_jump), .exmem_br_eq_i(exmem_br_eq), .exmem_br_inc_i(exmem_br_inc),
    .exmem_zero_i(exmem_zero), .memwb_rd_i(memwb_rd), .memwb_reg_write_i(memwb_reg_write),
    .for_a_o(for_a), .for_b_o(for_b), .hold_front_o(hold_front), .stall_o(stall),
    .isJumped_o(isJumped), .busy_o(busy), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clock = ~clock;

  task automatic idle();
    dec_rs = 0; dec_rt = 0; dec_use_rs = 0; dec_use_rt = 0;
    idex_rs = 0; idex_rt = 0; idex_rd = 0; idex_reg_write = 0; idex_mem_read = 0;
    idex_long_op = 0; idex_nop = 0;
    exmem_rd = 0; exmem_reg_write = 0; exmem_mem_read = 0;
    exmem_is_jump = 0; exmem_br_eq = 0; exmem_br_inc = 0; exmem_zero = 0;
    memwb_rd = 0; memwb_reg_write = 0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    idex_rs = 5; exmem_rd = 5; exmem_reg_write = 1; idex_long_op = 1; exmem_is_jump = 1;
    @(negedge clock);
    n_tests++;
    if ({for_a, for_b, hold_front, stall, isJumped, busy, stall_cnt, flush_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got fa=%b fb=%b h=%b s=%b j=%b b=%b sc=%0d fc=%0d exp all 0",
               for_a, for_b, hold_front, stall, isJumped, busy, stall_cnt, flush_cnt);
    end
    tick(); reset = 0; idle();
    @(negedge clock);
    n_tests++;
    if ({hold_front, busy, isJumped, stall_cnt, flush_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got h=%b b=%b j=%b sc=%0d fc=%0d exp 0",
               hold_front, busy, isJumped, stall_cnt, flush_cnt);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle(); idex_mem_read = 1; idex_reg_write = 1; idex_rd = 2;
    dec_rs = 2; dec_rt = 4; dec_use_rs = 1; dec_use_rt = 1;
    @(negedge clock);
    n_tests++;
    if ({hold_front, stall, isJumped} !== 3'b100) begin
      n_fail++;
      $display("FAIL load_use_hold: got h=%b s=%b j=%b exp 1 0 0", hold_front, stall, isJumped);
    end
    tick(); idle(); idex_nop = 1; exmem_rd = 2; exmem_reg_write = 1; exmem_mem_read = 1;
    dec_rs = 2; dec_rt = 4; dec_use_rs = 1; dec_use_rt = 1;
    @(negedge clock);
    n_tests++;
    if (hold_front !== 1'b0 || stall_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL load_use_release: got h=%b sc=%0d exp h=0 sc=1", hold_front, stall_cnt);
    end
    tick(); idle(); idex_rs = 2; idex_rt = 4; memwb_rd = 2; memwb_reg_write = 1;
    @(negedge clock);
    n_tests++;
    if (for_a !== 2'b10 || for_b !== 2'b00) begin
      n_fail++;
      $display("FAIL load_use_fwd: got fa=%b fb=%b exp 10 00", for_a, for_b);
    end
    tick(); idle(); idex_mem_read = 1; idex_reg_write = 1; idex_rd = 0; dec_rs = 0; dec_use_rs = 1;
    @(negedge clock);
    n_tests++;
    if (hold_front !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_r0: got h=%b exp 0", hold_front);
    end
    tick();
  endtask

  task automatic test_forward();
    idle(); idex_rs = 5; idex_rt = 5; exmem_rd = 5; exmem_reg_write = 1;
    @(negedge clock);
    n_tests++;
    if ({for_a, for_b, hold_front} !== 5'b01010) begin
      n_fail++;
      $display("FAIL fwd_ex: got fa=%b fb=%b h=%b exp 01 01 0", for_a, for_b, hold_front);
    end
    tick(); idle(); exmem_reg_write = 1; memwb_reg_write = 1;
    @(negedge clock);
    n_tests++;
    if ({for_a, for_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL fwd_r0: got fa=%b fb=%b exp 00 00", for_a, for_b);
    end
    tick(); idle(); idex_rs = 7; idex_rt = 3; exmem_rd = 7; exmem_reg_write = 1;
    memwb_rd = 7; memwb_reg_write = 1;
    @(negedge clock);
    n_tests++;
    if ({for_a, for_b} !== 4'b0100) begin
      n_fail++;
      $display("FAIL fwd_ex_priority: got fa=%b fb=%b exp 01 00", for_a, for_b);
    end
    tick(); exmem_mem_read = 1;
    @(negedge clock);
    n_tests++;
    if (for_a !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_load_in_ex: got fa=%b exp 10", for_a);
    end
    tick();
  endtask

  task automatic test_long_op(ref int exp_sc);
    idle(); idex_long_op = 1;
    for (int i = 0; i < LL; i++) begin
      @(negedge clock);
      n_tests++;
      if ({hold_front, stall, busy} !== ((i < LL - 1) ? 3'b111 : 3'b000)) begin
        n_fail++;
        $display("FAIL long_op_cycle%0d: got h=%b s=%b b=%b exp %b", i, hold_front, stall, busy,
                 (i < LL - 1) ? 3'b111 : 3'b000);
      end
      if (i < LL - 1) exp_sc++;
      tick();
    end
    idle();
    @(negedge clock);
    n_tests++;
    if (stall_cnt !== CW'(exp_sc) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL long_op_count: got sc=%0d b=%b exp sc=%0d b=0", stall_cnt, busy, exp_sc);
    end
    tick();
  endtask

  task automatic test_branch_flush();
    idle(); exmem_br_eq = 1; exmem_zero = 1; idex_long_op = 1;
    @(negedge clock);
    n_tests++;
    if ({isJumped, busy, hold_front} !== 3'b100) begin
      n_fail++;
      $display("FAIL flush_first: got j=%b b=%b h=%b exp 1 0 0", isJumped, busy, hold_front);
    end
    tick(); idle(); idex_nop = 1;
    @(negedge clock);
    n_tests++;
    if (isJumped !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_second: got j=%b b=%b exp 1 0", isJumped, busy);
    end
    tick(); idle(); exmem_br_inc = 1; exmem_zero = 1;
    @(negedge clock);
    n_tests++;
    if (isJumped !== 1'b0 || flush_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL flush_end: got j=%b fc=%0d exp j=0 fc=1", isJumped, flush_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    idle(); idex_long_op = 1;
    @(negedge clock);
    tick(); reset = 1;
    @(negedge clock);
    n_tests++;
    if ({hold_front, stall, busy, isJumped, stall_cnt, flush_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_busy: got h=%b s=%b b=%b j=%b sc=%0d fc=%0d exp all 0",
               hold_front, stall, busy, isJumped, stall_cnt, flush_cnt);
    end
    tick(); reset = 0; idle();
    @(negedge clock);
    n_tests++;
    if ({hold_front, busy, stall_cnt, flush_cnt} !== '0) begin
      n_fail++;
      $display("FAIL after_reset_run: got h=%b b=%b sc=%0d fc=%0d exp all 0",
               hold_front, busy, stall_cnt, flush_cnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    idle(); idex_mem_read = 1; idex_reg_write = 1; idex_rd = 9; dec_rt = 9; dec_use_rt = 1;
    for (int i = 0; i < CMAX + 6; i++) begin
      @(negedge clock);
      if (i == 10 || i == CMAX || i == CMAX + 5) begin
        n_tests++;
        if (stall_cnt !== CW'((i < CMAX) ? i : CMAX)) begin
          n_fail++;
          $display("FAIL stall_sat_at%0d: got %0d exp %0d", i, stall_cnt, (i < CMAX) ? i : CMAX);
        end
      end
      tick();
    end
    idle();
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (exmem_reg_write && !exmem_mem_read && exmem_rd != 0 && exmem_rd == src) return 2'b01;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_random();
    int busy_rem = 0, flush_rem = 0, sc = 0, fc = 0;
    bit supp = 0, supp_n, redir, lu;
    logic [1:0] e_fa, e_fb;
    logic e_h, e_s, e_j, e_b;
    int e_sc, e_fc;
    idle(); reset = 1; tick(); reset = 0;
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      dec_rs = 5'($urandom_range(0, 3)); dec_rt = 5'($urandom_range(0, 3));
      dec_use_rs = 1'($urandom); dec_use_rt = 1'($urandom);
      idex_rs = 5'($urandom_range(0, 3)); idex_rt = 5'($urandom_range(0, 3));
      idex_rd = 5'($urandom_range(0, 3));
      idex_reg_write = 1'($urandom); idex_mem_read = 1'($urandom);
      idex_long_op = ($urandom_range(0, 5) == 0); idex_nop = ($urandom_range(0, 7) == 0);
      exmem_rd = 5'($urandom_range(0, 3)); exmem_reg_write = 1'($urandom);
      exmem_mem_read = 1'($urandom);
      exmem_is_jump = ($urandom_range(0, 15) == 0); exmem_br_eq = ($urandom_range(0, 7) == 0);
      exmem_br_inc = ($urandom_range(0, 7) == 0); exmem_zero = 1'($urandom);
      memwb_rd = 5'($urandom_range(0, 3)); memwb_reg_write = 1'($urandom);

      redir = exmem_is_jump || (exmem_br_eq && exmem_zero) || (exmem_br_inc && !exmem_zero);
      lu = idex_mem_read && idex_reg_write && idex_rd != 0 &&
           ((dec_use_rs && dec_rs == idex_rd) || (dec_use_rt && dec_rt == idex_rd));
      {e_h, e_s, e_j, e_b} = 4'b0; supp_n = 0;
      if (reset) begin
        e_fa = 0; e_fb = 0; e_sc = 0; e_fc = 0;
        busy_rem = 0; flush_rem = 0; sc = 0; fc = 0;
      end else begin
        e_fa = ref_fwd(idex_rs); e_fb = ref_fwd(idex_rt); e_sc = sc; e_fc = fc;
        if (flush_rem > 0) begin
          e_j = 1;
          if (redir) begin fc++; flush_rem = FL - 1; end
          else flush_rem--;
        end else if (busy_rem > 0) begin
          {e_h, e_s, e_b} = 3'b111;
          busy_rem--;
          if (busy_rem == 0) supp_n = 1;
        end else if (redir) begin
          e_j = 1; fc++; flush_rem = FL - 1;
        end else if (idex_long_op && !idex_nop && !supp && LL > 1) begin
          {e_h, e_s, e_b} = 3'b111;
          busy_rem = LL - 2;
          if (busy_rem == 0) supp_n = 1;
        end else if (lu) begin
          e_h = 1;
        end
        if (e_h) sc++;
        if (sc > CMAX) sc = CMAX;
        if (fc > CMAX) fc = CMAX;
      end
      supp = supp_n;

      @(negedge clock);
      n_tests++;
      if ({for_a, for_b, hold_front, stall, isJumped, busy} !== {e_fa, e_fb, e_h, e_s, e_j, e_b}) begin
        n_fail++;
        $display("FAIL rand_ctrl c%0d: got fa,fb,h,s,j,b=%b exp %b", c,
                 {for_a, for_b, hold_front, stall, isJumped, busy}, {e_fa, e_fb, e_h, e_s, e_j, e_b});
      end
      n_tests++;
      if (stall_cnt !== CW'(e_sc) || flush_cnt !== CW'(e_fc)) begin
        n_fail++;
        $display("FAIL rand_counters c%0d: got sc=%0d fc=%0d exp sc=%0d fc=%0d", c,
                 stall_cnt, flush_cnt, e_sc, e_fc);
      end
      tick();
    end
    reset = 0; idle();
  endtask

  initial begin
    int exp_sc;
    test_reset();
    test_load_use();
    test_forward();
    exp_sc = 1;
    test_long_op(exp_sc);
    test_branch_flush();
    test_reset_mid_busy();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
